// File: rtl/k12a_sequencer_if.sv
// ============================================================================
// Module      : k12a_sequencer_pkg / k12a_sequencer_if
// Description : Control-state types and the FSM/datapath/debug bundle that
//               connects to the k12a sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package k12a_sequencer_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH1 = 3'd0,
        STATE_FETCH2 = 3'd1,
        STATE_FETCH3 = 3'd2,
        STATE_EXEC   = 3'd3,
        STATE_HALT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SKIP_SEL_0                  = 2'd0,
        SKIP_SEL_CONDITION          = 2'd1,
        SKIP_SEL_CONDITION_INVERTED = 2'd2,
        SKIP_SEL_HOLD               = 2'd3
    } skip_sel_t;

endpackage

interface k12a_sequencer_if
    import k12a_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16
);
    state_t                   next_state;
    logic                     inst_high_store;
    logic                     inst_low_store;
    logic                     skip_store;
    skip_sel_t                skip_sel;
    logic                     alu_condition;
    logic [7:0]               data_bus;
    logic                     run;
    logic                     step_req;
    logic                     resume;
    logic                     counter_clear;

    state_t                   state;
    logic [15:0]              inst;
    logic                     skip;
    logic                     cycle_enable;
    logic                     halted;
    logic                     stopped;
    logic                     retired;
    logic [COUNTER_WIDTH-1:0] retired_count;

    modport master (
        output next_state, inst_high_store, inst_low_store, skip_store,
               skip_sel, alu_condition, data_bus, run, step_req, resume,
               counter_clear,
        input  state, inst, skip, cycle_enable, halted, stopped, retired,
               retired_count
    );

    modport slave (
        input  next_state, inst_high_store, inst_low_store, skip_store,
               skip_sel, alu_condition, data_bus, run, step_req, resume,
               counter_clear,
        output state, inst, skip, cycle_enable, halted, stopped, retired,
               retired_count
    );

endinterface

`default_nettype wire

// File: rtl/k12a_sequencer.sv
// ============================================================================
// Module      : k12a_sequencer
// Description : k12a control-state register, instruction register, skip flag,
//               debug run/step/resume gating and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module k12a_sequencer
    import k12a_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter bit SYNC_DEBUG    = 1'b1
) (
    input wire              clock,
    input wire              reset_n,
    k12a_sequencer_if.slave bus
);

    logic                     w_run_s;
    logic                     w_step_s;
    logic                     w_resume_s;
    logic                     w_step_p;
    logic                     w_resume_p;
    logic                     w_cycle_enable;
    logic                     w_retire;

    state_t                   r_state;
    logic [7:0]               r_inst_high;
    logic [7:0]               r_inst_low;
    logic                     r_skip;
    logic                     r_retired;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_step_prev;
    logic                     r_resume_prev;

    if (SYNC_DEBUG) begin : g_sync
        logic [1:0] r_run_sync;
        logic [1:0] r_step_sync;
        logic [1:0] r_resume_sync;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_run_sync    <= 2'b00;
                r_step_sync   <= 2'b00;
                r_resume_sync <= 2'b00;
            end else begin
                r_run_sync    <= {r_run_sync[0],    bus.run};
                r_step_sync   <= {r_step_sync[0],   bus.step_req};
                r_resume_sync <= {r_resume_sync[0], bus.resume};
            end
        end

        assign w_run_s    = r_run_sync[1];
        assign w_step_s   = r_step_sync[1];
        assign w_resume_s = r_resume_sync[1];
    end else begin : g_nosync
        assign w_run_s    = bus.run;
        assign w_step_s   = bus.step_req;
        assign w_resume_s = bus.resume;
    end

    assign w_step_p   = w_step_s   & ~r_step_prev;
    assign w_resume_p = w_resume_s & ~r_resume_prev;

    // Only the FETCH1 boundary is gated by debug; a started instruction runs to completion.
    always_comb begin
        w_cycle_enable = 1'b1;
        case (r_state)
            STATE_HALT:   w_cycle_enable = 1'b0;
            STATE_FETCH1: w_cycle_enable = w_run_s | w_step_p;
            default:      w_cycle_enable = 1'b1;
        endcase
    end

    assign w_retire = w_cycle_enable & (r_state != STATE_FETCH1) &
                      ((bus.next_state == STATE_FETCH1) || (bus.next_state == STATE_HALT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= STATE_FETCH1;
            r_inst_high   <= 8'h00;
            r_inst_low    <= 8'h00;
            r_skip        <= 1'b0;
            r_retired     <= 1'b0;
            r_count       <= '0;
            r_step_prev   <= 1'b0;
            r_resume_prev <= 1'b0;
        end else begin
            r_step_prev   <= w_step_s;
            r_resume_prev <= w_resume_s;
            r_retired     <= w_retire;

            if (w_cycle_enable) begin
                r_state <= bus.next_state;
            end else if ((r_state == STATE_HALT) && w_resume_p) begin
                r_state <= STATE_FETCH1;
            end

            if (bus.inst_high_store && w_cycle_enable) begin
                r_inst_high <= bus.data_bus;
            end
            if (bus.inst_low_store && w_cycle_enable) begin
                r_inst_low <= bus.data_bus;
            end

            if (bus.skip_store && w_cycle_enable) begin
                case (bus.skip_sel)
                    SKIP_SEL_0:                  r_skip <= 1'b0;
                    SKIP_SEL_CONDITION:          r_skip <= bus.alu_condition;
                    SKIP_SEL_CONDITION_INVERTED: r_skip <= ~bus.alu_condition;
                    default:                     r_skip <= r_skip;
                endcase
            end

            // Clear takes priority over a coincident retire.
            if (bus.counter_clear) begin
                r_count <= '0;
            end else if (w_retire) begin
                r_count <= r_count + COUNTER_WIDTH'(1);
            end
        end
    end

    assign bus.state         = r_state;
    assign bus.inst          = {r_inst_high, r_inst_low};
    assign bus.skip          = r_skip;
    assign bus.cycle_enable  = w_cycle_enable;
    assign bus.halted        = (r_state == STATE_HALT);
    assign bus.stopped       = (r_state == STATE_FETCH1) & ~w_run_s & ~w_step_p;
    assign bus.retired       = r_retired;
    assign bus.retired_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_k12a_sequencer.sv
// ============================================================================
// Module      : tb_k12a_sequencer
// Description : Directed self-checking bench for k12a_sequencer with an FSM
//               stub and a retired-count scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_k12a_sequencer;
    import k12a_sequencer_pkg::*;

    // Narrow counter keeps the wrap-around test short.
    localparam int            CW   = 8;
    localparam logic [CW-1:0] CMAX = '1;

    logic clock = 1'b0;
    logic reset_n;
    logic halt_req;
    logic [7:0] hi_byte;
    logic [7:0] lo_byte;

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] sb_model;
    logic [CW-1:0] sb_q[$];

    always #5 clock = ~clock;

    k12a_sequencer_if #(.COUNTER_WIDTH(CW)) bus();

    k12a_sequencer #(
        .COUNTER_WIDTH (CW),
        .SYNC_DEBUG    (1'b0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic state_t stub_next(state_t s, logic h);
        case (s)
            STATE_FETCH1: return STATE_FETCH2;
            STATE_FETCH2: return STATE_FETCH3;
            STATE_FETCH3: return STATE_EXEC;
            STATE_EXEC:   return h ? STATE_HALT : STATE_FETCH1;
            STATE_HALT:   return STATE_HALT;
            default:      return STATE_FETCH1;
        endcase
    endfunction

    assign bus.next_state      = stub_next(bus.state, halt_req);
    assign bus.inst_high_store = (bus.state == STATE_FETCH1);
    assign bus.inst_low_store  = (bus.state == STATE_FETCH2);
    assign bus.data_bus        = (bus.state == STATE_FETCH1) ? hi_byte : lo_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_retire();
        sb_model = sb_model + CW'(1);
        sb_q.push_back(sb_model);
    endtask

    // One clock; any retired pulse is matched against the scoreboard.
    task automatic tick();
        logic [CW-1:0] exp_cnt;
        @(posedge clock);
        #1;
        if (bus.retired === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_retire observed=%0h expected=none", bus.retired_count);
            end
            if (sb_q.size() != 0) begin
                exp_cnt = sb_q.pop_front();
                chk("retired_count", 32'(bus.retired_count), 32'(exp_cnt));
            end
        end
    endtask

    task automatic wait_retire(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL retire_timeout observed=%0d_pending expected=0_pending", sb_q.size());
        end
    endtask

    task automatic step_once();
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
    endtask

    initial begin
        reset_n           = 1'b0;
        halt_req          = 1'b0;
        hi_byte           = 8'h00;
        lo_byte           = 8'h00;
        sb_model          = '0;
        bus.skip_store    = 1'b0;
        bus.skip_sel      = SKIP_SEL_HOLD;
        bus.alu_condition = 1'b0;
        bus.run           = 1'b0;
        bus.step_req      = 1'b0;
        bus.resume        = 1'b0;
        bus.counter_clear = 1'b0;
        #1;
        chk("rst_state",   32'(bus.state), 32'(STATE_FETCH1));
        chk("rst_inst",    32'(bus.inst), 32'h0000);
        chk("rst_skip",    32'(bus.skip), 32'd0);
        chk("rst_count",   32'(bus.retired_count), 32'd0);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_stopped", 32'(bus.stopped), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Free-run one instruction and load A53C.
        hi_byte = 8'hA5;
        lo_byte = 8'h3C;
        expect_retire();
        bus.run = 1'b1;
        tick();
        chk("fetch2_state", 32'(bus.state), 32'(STATE_FETCH2));
        tick();
        chk("inst_a53c", 32'(bus.inst), 32'hA53C);
        wait_retire(8);
        bus.run = 1'b0;
        chk("count_one", 32'(bus.retired_count), 32'd1);
        tick();
        chk("retired_single_pulse", 32'(bus.retired), 32'd0);
        chk("stop_state", 32'(bus.state), 32'(STATE_FETCH1));
        chk("stop_cycle_en", 32'(bus.cycle_enable), 32'd0);

        // Skip store while stopped is gated off.
        bus.skip_store    = 1'b1;
        bus.skip_sel      = SKIP_SEL_CONDITION_INVERTED;
        bus.alu_condition = 1'b0;
        tick();
        chk("skip_hold_stopped", 32'(bus.skip), 32'd0);

        // Run, then drop run during FETCH2: instruction must still finish.
        expect_retire();
        bus.run = 1'b1;
        tick();
        bus.skip_store = 1'b0;
        bus.run        = 1'b0;
        chk("skip_inverted", 32'(bus.skip), 32'd1);
        wait_retire(8);
        tick();
        tick();
        chk("run_drop_state", 32'(bus.state), 32'(STATE_FETCH1));
        chk("run_drop_stopped", 32'(bus.stopped), 32'd1);
        chk("run_drop_cycle_en", 32'(bus.cycle_enable), 32'd0);

        // Three single steps.
        bus.skip_store = 1'b1;
        bus.skip_sel   = SKIP_SEL_0;
        expect_retire();
        step_once();
        bus.skip_store = 1'b0;
        chk("skip_sel0", 32'(bus.skip), 32'd0);
        wait_retire(8);
        chk("step1_stopped", 32'(bus.stopped), 32'd1);

        bus.skip_store    = 1'b1;
        bus.skip_sel      = SKIP_SEL_CONDITION;
        bus.alu_condition = 1'b1;
        expect_retire();
        step_once();
        bus.skip_store = 1'b0;
        chk("skip_condition", 32'(bus.skip), 32'd1);
        wait_retire(8);
        chk("step2_stopped", 32'(bus.stopped), 32'd1);

        expect_retire();
        step_once();
        wait_retire(8);
        tick();
        chk("step3_state", 32'(bus.state), 32'(STATE_FETCH1));
        chk("step3_count", 32'(bus.retired_count), 32'd5);

        // Halt, ignored step, resume.
        halt_req = 1'b1;
        expect_retire();
        step_once();
        wait_retire(8);
        halt_req = 1'b0;
        chk("halted", 32'(bus.halted), 32'd1);
        chk("halt_cycle_en", 32'(bus.cycle_enable), 32'd0);
        chk("halt_not_stopped", 32'(bus.stopped), 32'd0);
        step_once();
        repeat (19) tick();
        chk("halt_hold_state", 32'(bus.state), 32'(STATE_HALT));
        chk("halt_count", 32'(bus.retired_count), 32'd6);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk("resume_state", 32'(bus.state), 32'(STATE_FETCH1));
        chk("resume_halted", 32'(bus.halted), 32'd0);
        tick();
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk("resume_ignored_state", 32'(bus.state), 32'(STATE_FETCH1));
        chk("resume_ignored_count", 32'(bus.retired_count), 32'd6);

        // Count up to all-ones, then wrap.
        bus.run = 1'b1;
        while (sb_model != CMAX) begin
            expect_retire();
            wait_retire(8);
        end
        chk("count_max", 32'(bus.retired_count), 32'(CMAX));
        expect_retire();
        wait_retire(8);
        chk("count_wrap", 32'(bus.retired_count), 32'd0);

        // Clear coincident with a retire (count would otherwise become 1).
        tick();
        tick();
        tick();
        chk("clear_exec_state", 32'(bus.state), 32'(STATE_EXEC));
        bus.counter_clear = 1'b1;
        sb_model = '0;
        sb_q.push_back(sb_model);
        tick();
        bus.counter_clear = 1'b0;
        bus.run           = 1'b0;
        chk("clear_wins", 32'(bus.retired_count), 32'd0);

        // Async reset mid-EXEC.
        expect_retire();
        step_once();
        wait_retire(8);
        hi_byte           = 8'h12;
        lo_byte           = 8'h34;
        bus.skip_store    = 1'b1;
        bus.skip_sel      = SKIP_SEL_CONDITION;
        bus.alu_condition = 1'b1;
        step_once();
        bus.skip_store = 1'b0;
        tick();
        tick();
        chk("pre_rst_state", 32'(bus.state), 32'(STATE_EXEC));
        chk("pre_rst_inst", 32'(bus.inst), 32'h1234);
        chk("pre_rst_skip", 32'(bus.skip), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state), 32'(STATE_FETCH1));
        chk("async_rst_inst", 32'(bus.inst), 32'h0000);
        chk("async_rst_skip", 32'(bus.skip), 32'd0);
        chk("async_rst_count", 32'(bus.retired_count), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d_pending expected=0_pending", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/k12a_sequencer.md
Name: k12a_sequencer

Overview:
Holds the k12a control state fed to the control FSM: the state register, the 16-bit instruction register (high/low byte halves), and the skip flag. Each cycle it registers the FSM's next_state and store strobes. It also provides debug run/stop, single-step and resume-from-halt control, plus an instruction-retired counter. Its cycle_enable output gates every architectural store in the datapath.

Parameters:
COUNTER_WIDTH, 16, width of retired-instruction counter (wraps modulo 2^COUNTER_WIDTH)
SYNC_DEBUG, 1, 1 = 2-flop synchronisers on run/step_req/resume; 0 = those inputs are already synchronous to clock

Ports:
clock  input  1  system clock, all flops rising-edge
reset_n  input  1  asynchronous active-low reset
next_state  input  state_t  FSM next-state request
inst_high_store  input  1  load inst[15:8] from data_bus
inst_low_store  input  1  load inst[7:0] from data_bus
skip_store  input  1  update skip flag
skip_sel  input  skip_sel_t  skip source select
alu_condition  input  1  ALU condition result
data_bus  input  8  system data bus
run  input  1  level: 1 = free-run, 0 = stop at instruction boundary
step_req  input  1  rising edge requests one instruction while stopped
resume  input  1  rising edge leaves STATE_HALT
counter_clear  input  1  synchronous clear of retired count
state  output  state_t  current state to FSM
inst  output  16  {inst_high, inst_low}
skip  output  1  current skip flag
cycle_enable  output  1  1 = this cycle's stores commit (datapath ANDs into all *_store)
halted  output  1  state == STATE_HALT
stopped  output  1  debug-stopped at FETCH1 boundary
retired  output  1  one-cycle pulse when an instruction completes
retired_count  output  COUNTER_WIDTH  retired-instruction count

Behaviour:
- Reset (async, reset_n=0): state=STATE_FETCH1, inst=16'h0000, skip=0, retired_count=0, retired=0, synchroniser and edge-detect flops=0. Outputs valid immediately on reset assertion.
- Debug inputs: with SYNC_DEBUG=1, run/step_req/resume pass through 2 flops (2-cycle latency). step_p / resume_p = synchronised rising edges (registered previous value, 1-cycle pulse).
- cycle_enable (combinational):
  - state==STATE_HALT: 0.
  - state==STATE_FETCH1: run_s | step_p.
  - any other state: 1. A started instruction always completes, even if run drops mid-instruction.
- State register: if cycle_enable, state<=next_state. Else if state==HALT and resume_p, state<=STATE_FETCH1. Otherwise hold.
- inst_high<=data_bus when inst_high_store & cycle_enable. inst_low<=data_bus when inst_low_store & cycle_enable. Both strobes together: both load.
- skip: when skip_store & cycle_enable:
  - SKIP_SEL_0 -> 0
  - SKIP_SEL_CONDITION -> alu_condition
  - SKIP_SEL_CONDITION_INVERTED -> ~alu_condition
  - Otherwise hold.
- Retire event = cycle_enable & (state != FETCH1) & (next_state == FETCH1 | next_state == HALT).
- retired: registered, high the cycle after a retire event.
- retired_count: +1 per retire event, wraps all-ones->0. counter_clear wins over a simultaneous retire (result 0).
- stopped (combinational) = (state==FETCH1) & ~run_s & ~step_p.
- halted (combinational) = (state==HALT).
- resume_p or step_p outside their valid state (not HALT / not stopped FETCH1): ignored, no effect.
- step_p while run_s=1: no extra effect.
- Reset asserted mid-instruction: abandon immediately, all registers to reset values.

Test Plan:
- Reset, run=1, FSM stub cycles FETCH1->FETCH2->FETCH3->EXEC->FETCH1, data_bus 8'hA5 on FETCH1 and 8'h3C on FETCH2 -> inst=16'hA53C after FETCH2, retired pulses once, retired_count=1.
- skip_store with CONDITION_INVERTED, alu_condition=0 -> skip=1. Next FETCH1 with SKIP_SEL_0 -> skip=0. Same strobes with run=0 at FETCH1 -> skip unchanged.
- run=0 (SYNC_DEBUG=0) asserted during FETCH2 -> FETCH3, EXEC complete, state holds FETCH1, stopped=1, cycle_enable=0. Three step_req pulses -> retired_count +3, stopped again after each instruction.
- next_state=HALT from EXEC -> halted=1, retired_count +1, state holds for 20 cycles. resume edge -> state=FETCH1 next cycle. resume while not halted -> no change.
- Preload count 16'hFFFF via 65535 retires (or force) -> next retire gives 0. counter_clear coincident with a retire -> 0.
- reset_n low during EXEC with inst=16'h1234, skip=1 -> state=FETCH1, inst=0, skip=0, retired_count=0 asynchronously, before the next clock edge.
